// File: rtl/pulse_gater_pkg.sv
// Shared definitions for the NMR pulse gater: FSM state encoding, unity amplitude
// and the saturation limits of the 14-bit sample path.
package pulse_gater_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } gater_state_t;

  localparam logic [15:0] AMP_UNITY = 16'h8000;
  localparam int          SAT_MAX   = 8191;
  localparam int          SAT_MIN   = -8192;

endpackage

// File: rtl/axis_amp_scaler.sv
// Combinational amplitude scaler: signed sample times unsigned Q1.15 amplitude,
// floor shift back to sample scale, then saturation to the sample width.
module axis_amp_scaler #(
  parameter int DATA_WIDTH = 14,
  parameter int AMP_WIDTH  = 16
) (
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [AMP_WIDTH-1:0]  amp,
  output logic [DATA_WIDTH-1:0] scaled
);

  // Product of a DATA_WIDTH signed value and an AMP_WIDTH+1 signed (always positive) value.
  localparam int PROD_WIDTH = DATA_WIDTH + AMP_WIDTH + 1;

  localparam logic signed [PROD_WIDTH-1:0] LIM_HI =
    {{(PROD_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_WIDTH-1:0] LIM_LO =
    {{(PROD_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [PROD_WIDTH-1:0] product;
  logic signed [PROD_WIDTH-1:0] shifted;

  always_comb begin
    product = PROD_WIDTH'($signed(sample)) * PROD_WIDTH'($signed({1'b0, amp}));
    // Arithmetic shift rounds toward minus infinity, so -1.5 becomes -2.
    shifted = product >>> (AMP_WIDTH - 1);
    if (shifted > LIM_HI) begin
      scaled = LIM_HI[DATA_WIDTH-1:0];
    end else if (shifted < LIM_LO) begin
      scaled = LIM_LO[DATA_WIDTH-1:0];
    end else begin
      scaled = shifted[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/axis_pulse_gater.sv
// Gates a continuous NCO sample stream into a triggered train of scaled excitation pulses,
// with a sample-aligned gate line for RF amplifier blanking.
module axis_pulse_gater
  import pulse_gater_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 14,
  parameter int CNTR_WIDTH       = 32,
  parameter int AMP_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        trigger,
  input  logic [CNTR_WIDTH-1:0]       cfg_delay,
  input  logic [CNTR_WIDTH-1:0]       cfg_width,
  input  logic [CNTR_WIDTH-1:0]       cfg_gap,
  input  logic [CNTR_WIDTH-1:0]       cfg_count,
  input  logic [AMP_WIDTH-1:0]        cfg_amp,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        gate,
  output logic                        busy
);

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

  gater_state_t                state, state_nxt;
  logic [CNTR_WIDTH-1:0]       cnt, cnt_nxt;
  logic [CNTR_WIDTH-1:0]       rem, rem_nxt;
  logic [CNTR_WIDTH-1:0]       width_q, width_nxt;
  logic [CNTR_WIDTH-1:0]       gap_q, gap_nxt;
  logic [CNTR_WIDTH-1:0]       count_q, count_nxt;
  logic [AMP_WIDTH-1:0]        amp_q, amp_nxt;
  logic                        trig_q;
  logic                        trig_pend;
  logic                        trig_rise;
  logic                        trig_evt;
  logic                        strb;
  logic                        in_pulse;
  logic [AXIS_TDATA_WIDTH-1:0] scaled;

  assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
  assign strb          = s_axis_tvalid & s_axis_tready;
  assign busy          = (state != IDLE);
  assign in_pulse      = (state == PULSE);
  assign trig_rise     = trigger & ~trig_q;
  assign trig_evt      = trig_pend | trig_rise;

  axis_amp_scaler #(
    .DATA_WIDTH (AXIS_TDATA_WIDTH),
    .AMP_WIDTH  (AMP_WIDTH)
  ) u_scaler (
    .sample (s_axis_tdata),
    .amp    (amp_q),
    .scaled (scaled)
  );

  // An edge seen between strobes while idle is held until the next strobe consumes it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      count_q   <= '0;
      amp_q     <= '0;
      trig_q    <= 1'b0;
      trig_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rem       <= rem_nxt;
      width_q   <= width_nxt;
      gap_q     <= gap_nxt;
      count_q   <= count_nxt;
      amp_q     <= amp_nxt;
      trig_q    <= trigger;
      trig_pend <= strb ? 1'b0 : (trig_pend | (trig_rise & (state == IDLE)));
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    width_nxt = width_q;
    gap_nxt   = gap_q;
    count_nxt = count_q;
    amp_nxt   = amp_q;
    if (strb) begin
      case (state)
        IDLE: begin
          if (trig_evt && (cfg_count != '0) && (cfg_width != '0)) begin
            width_nxt = cfg_width;
            gap_nxt   = cfg_gap;
            count_nxt = cfg_count;
            amp_nxt   = cfg_amp;
            rem_nxt   = cfg_count;
            if (cfg_delay == '0) begin
              state_nxt = PULSE;
              cnt_nxt   = cfg_width;
            end else begin
              state_nxt = DELAY;
              cnt_nxt   = cfg_delay;
            end
          end
        end
        DELAY: begin
          if (cnt == CNT_ONE) begin
            state_nxt = PULSE;
            cnt_nxt   = width_q;
            rem_nxt   = count_q;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        // A zero gap chains pulses back to back without visiting GAP.
        PULSE: begin
          if (cnt == CNT_ONE) begin
            rem_nxt = rem - CNT_ONE;
            if (rem == CNT_ONE) begin
              state_nxt = IDLE;
            end else if (gap_q == '0) begin
              state_nxt = PULSE;
              cnt_nxt   = width_q;
            end else begin
              state_nxt = GAP;
              cnt_nxt   = gap_q;
            end
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == CNT_ONE) begin
            state_nxt = PULSE;
            cnt_nxt   = width_q;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // One-deep output slice; data and gate are chosen by the state that accepted the sample.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      gate          <= 1'b0;
    end else if (strb) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= in_pulse ? scaled : '0;
      gate          <= in_pulse;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_pulse_gater.sv
// Directed scoreboard bench for axis_pulse_gater: a sample-index model predicts each
// accepted sample's output, which is checked when it leaves the output slice.
module tb_axis_pulse_gater;
  import pulse_gater_pkg::*;

  typedef struct packed {
    logic [13:0] data;
    logic        gate;
  } exp_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        trigger;
  logic [31:0] cfg_delay, cfg_width, cfg_gap, cfg_count;
  logic [15:0] cfg_amp;
  logic [13:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [13:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        gate;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  exp_t        sb[$];
  logic        exp_mvalid;
  bit          active, armed, prev_trig;
  int          n, last_idx;
  int          m_delay, m_width, m_gap, m_count, m_amp;
  logic        trig_level;
  logic [13:0] ramp;
  int          gate_cnt, cur_run, max_run;

  always #5 aclk = ~aclk;

  axis_pulse_gater #(
    .AXIS_TDATA_WIDTH (14),
    .CNTR_WIDTH       (32),
    .AMP_WIDTH        (16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .trigger       (trigger),
    .cfg_delay     (cfg_delay),
    .cfg_width     (cfg_width),
    .cfg_gap       (cfg_gap),
    .cfg_count     (cfg_count),
    .cfg_amp       (cfg_amp),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .gate          (gate),
    .busy          (busy)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  function automatic logic [31:0] sx14(input logic [13:0] v);
    return {{18{v[13]}}, v};
  endfunction

  // Reference: index 0 is the trigger sample, then delay zeros, then width/gap periods.
  function automatic bit model_pulse(input int idx);
    int j;
    int p;
    j = idx - 1 - m_delay;
    if (j < 0) return 1'b0;
    p = m_width + m_gap;
    return ((j / p) < m_count) && ((j % p) < m_width);
  endfunction

  function automatic logic [13:0] model_scale(input logic [13:0] d, input int amp);
    longint p;
    p = longint'($signed(d)) * longint'(amp);
    p = p >>> 15;
    if (p > SAT_MAX) p = SAT_MAX;
    if (p < SAT_MIN) p = SAT_MIN;
    return 14'(p);
  endfunction

  task automatic setCfg(input int d, input int w, input int g, input int c, input logic [15:0] a);
    cfg_delay = 32'(d);
    cfg_width = 32'(w);
    cfg_gap   = 32'(g);
    cfg_count = 32'(c);
    cfg_amp   = a;
  endtask

  task automatic resetStats();
    gate_cnt = 0;
    cur_run  = 0;
    max_run  = 0;
  endtask

  // One clock: drive, check just before the edge, update the model, return at edge+1.
  task automatic applyStimulus(input logic [13:0] data, input logic valid, input logic ready);
    logic exp_sready;
    bit   acc_in;
    bit   rise;
    bit   pl;
    exp_t e;
    s_axis_tdata  = data;
    s_axis_tvalid = valid;
    m_axis_tready = ready;
    trigger       = trig_level;
    @(negedge aclk);
    exp_sready = ready | ~exp_mvalid;
    checkOutput("s_tready", {31'b0, s_axis_tready}, {31'b0, exp_sready});
    checkOutput("m_tvalid", {31'b0, m_axis_tvalid}, {31'b0, exp_mvalid});
    checkOutput("busy", {31'b0, busy}, {31'b0, active});
    if (exp_mvalid) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", sb.size(), 1);
      end else begin
        checkOutput("tdata", sx14(m_axis_tdata), sx14(sb[0].data));
        checkOutput("gate", {31'b0, gate}, {31'b0, sb[0].gate});
        if (ready) begin
          if (gate === 1'b1) begin
            gate_cnt++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
          end else begin
            cur_run = 0;
          end
          void'(sb.pop_front());
        end
      end
    end
    rise   = trig_level & ~prev_trig;
    acc_in = valid & exp_sready;
    if (acc_in) begin
      pl     = active && model_pulse(n);
      e.gate = pl;
      e.data = pl ? model_scale(data, m_amp) : 14'd0;
      sb.push_back(e);
      if (active) begin
        n++;
        if (n > last_idx) active = 1'b0;
      end else if (armed || rise) begin
        if (cfg_count != 0 && cfg_width != 0) begin
          m_delay  = int'(cfg_delay);
          m_width  = int'(cfg_width);
          m_gap    = int'(cfg_gap);
          m_count  = int'(cfg_count);
          m_amp    = int'(cfg_amp);
          last_idx = m_delay + (m_count - 1) * (m_width + m_gap) + m_width;
          active   = 1'b1;
          n        = 1;
        end
      end
      armed = 1'b0;
    end else if (rise && !active) begin
      armed = 1'b1;
    end
    exp_mvalid = acc_in ? 1'b1 : (ready ? 1'b0 : exp_mvalid);
    prev_trig  = trig_level;
    @(posedge aclk);
    #1;
  endtask

  task automatic stepRamp(input logic valid, input logic ready);
    applyStimulus(ramp, valid, ready);
    ramp = ramp + 14'd1;
  endtask

  task automatic doReset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    trigger       = trig_level;
    @(posedge aclk);
    #1;
    sb.delete();
    exp_mvalid = 1'b0;
    active     = 1'b0;
    armed      = 1'b0;
    prev_trig  = 1'b0;
    n          = 0;
    checkOutput("rst_tvalid", {31'b0, m_axis_tvalid}, 0);
    checkOutput("rst_tdata", sx14(m_axis_tdata), 0);
    checkOutput("rst_gate", {31'b0, gate}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    aresetn = 1'b1;
  endtask

  task automatic drainAll();
    int budget;
    budget     = 300;
    trig_level = 1'b0;
    while ((active || armed) && budget > 0) begin
      stepRamp(1'b1, 1'b1);
      budget--;
    end
    repeat (2) applyStimulus(ramp, 1'b0, 1'b1);
    checkOutput("drain_active", {31'b0, active}, 0);
    checkOutput("drain_sb", sb.size(), 0);
  endtask

  initial begin
    int vals_a[7];
    int vals_b[5];
    vals_a = '{0, 8191, -8192, 8191, -8192, 1000, -1000};
    vals_b = '{0, -3, 3, -1, 1};
    trig_level = 1'b0;
    ramp       = 14'd1;
    setCfg(0, 0, 0, 0, 16'h0000);
    s_axis_tdata = '0;
    resetStats();
    doReset();

    $display("[TB] test 1: basic delay/width/gap/count sequence");
    setCfg(3, 4, 2, 2, AMP_UNITY);
    resetStats();
    trig_level = 1'b1;
    repeat (4) stepRamp(1'b1, 1'b1);
    drainAll();
    checkOutput("t1_gate_count", gate_cnt, 8);

    $display("[TB] test 2: scaling, saturation and floor");
    setCfg(0, 6, 0, 1, 16'hFFFF);
    trig_level = 1'b1;
    foreach (vals_a[i]) begin
      applyStimulus(14'(vals_a[i]), 1'b1, 1'b1);
      trig_level = 1'b0;
    end
    drainAll();
    setCfg(0, 4, 0, 1, 16'h4000);
    trig_level = 1'b1;
    foreach (vals_b[i]) begin
      applyStimulus(14'(vals_b[i]), 1'b1, 1'b1);
      trig_level = 1'b0;
    end
    drainAll();

    $display("[TB] test 3: random backpressure and source gaps");
    setCfg(3, 4, 2, 2, AMP_UNITY);
    resetStats();
    trig_level = 1'b1;
    stepRamp(1'b1, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (i == 1) trig_level = 1'b0;
      stepRamp(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0));
    end
    drainAll();
    checkOutput("t3_gate_count", gate_cnt, 8);

    $display("[TB] test 4: ignored triggers");
    setCfg(1, 5, 1, 2, AMP_UNITY);
    resetStats();
    trig_level = 1'b1;
    repeat (2) stepRamp(1'b1, 1'b1);
    trig_level = 1'b0;
    repeat (3) stepRamp(1'b1, 1'b1);
    trig_level = 1'b1;
    repeat (20) stepRamp(1'b1, 1'b1);
    repeat (5) stepRamp(1'b1, 1'b1);
    checkOutput("t4_held_busy", {31'b0, busy}, 0);
    drainAll();
    checkOutput("t4_gate_count", gate_cnt, 10);
    setCfg(0, 2, 0, 1, AMP_UNITY);
    resetStats();
    trig_level = 1'b1;
    stepRamp(1'b1, 1'b1);
    trig_level = 1'b0;
    stepRamp(1'b1, 1'b1);
    trig_level = 1'b1;
    repeat (5) stepRamp(1'b1, 1'b1);
    drainAll();
    checkOutput("t4_final_edge_gates", gate_cnt, 2);
    setCfg(0, 4, 0, 0, AMP_UNITY);
    trig_level = 1'b1;
    repeat (6) stepRamp(1'b1, 1'b1);
    checkOutput("t4_count0_busy", {31'b0, busy}, 0);
    trig_level = 1'b0;
    stepRamp(1'b1, 1'b1);
    setCfg(0, 0, 0, 3, AMP_UNITY);
    trig_level = 1'b1;
    repeat (6) stepRamp(1'b1, 1'b1);
    checkOutput("t4_width0_busy", {31'b0, busy}, 0);
    drainAll();

    $display("[TB] test 5: zero delay and zero gap");
    setCfg(0, 2, 0, 3, AMP_UNITY);
    resetStats();
    trig_level = 1'b1;
    stepRamp(1'b1, 1'b1);
    trig_level = 1'b0;
    repeat (10) stepRamp(1'b1, 1'b1);
    drainAll();
    checkOutput("t5_gate_count", gate_cnt, 6);
    checkOutput("t5_gate_run", max_run, 6);

    $display("[TB] test 6: reset mid-pulse then fresh sequence");
    setCfg(1, 8, 0, 1, AMP_UNITY);
    trig_level = 1'b1;
    stepRamp(1'b1, 1'b1);
    trig_level = 1'b0;
    repeat (4) stepRamp(1'b1, 1'b1);
    checkOutput("t6_pre_gate", {31'b0, gate}, 1);
    doReset();
    setCfg(2, 3, 1, 2, AMP_UNITY);
    resetStats();
    trig_level = 1'b1;
    repeat (3) stepRamp(1'b1, 1'b1);
    drainAll();
    checkOutput("t6_gate_count", gate_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
